cache_ram_ctrl: RTL

Parametrised direct-mapped, write-through cache controller in front of a handshaked backing RAM. Successor to the fixed-width cache/RAM pair: a single request port with explicit ready/valid handshake replaces change-detection on inputs, and it adds configurable geometry, hit/miss tracking and miss refill. Sits between a requester (CPU model or testbench) and the RAM model.

---
 rtl/cache_pkg.sv | 17 +
 rtl/cache_line_store.sv | 47 ++++
 rtl/cache_ram_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache.
// State encoding, request mode constants and statistics counter width.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        RAM_ACC = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic CACHE_RD = 1'b0;
    localparam logic CACHE_WR = 1'b1;

    localparam int STATS_W = 32;

endpackage

// File: rtl/cache_line_store.sv
// LINES-deep valid/tag/data line array, combinational read, single write.
// Ports: clk, rst (sync, clears valid bits), i_rd_idx -> o_rd_valid/tag/data; i_we, i_wr_idx/tag/data.
module cache_line_store
    import cache_pkg::*;
#(
    parameter int LINES  = 16,
    parameter int IDX_W  = 4,
    parameter int TAG_W  = 28,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are qualified by the valid bit.
    always_ff @(posedge clk) begin
        if (i_we && !rst) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];

endmodule

// File: rtl/cache_ram_ctrl.sv
// Direct-mapped write-through cache controller with a handshaked backing RAM.
// Ports: req_* (ready/valid request), resp_* (completion pulse), ram_* (RAM handshake);
// hit_cnt/miss_cnt present only when CACHE_STATS_EN is defined.
module cache_ram_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINES  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_hit,
    output logic              ram_req,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic              ram_ack,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [STATS_W-1:0] hit_cnt,
    output logic [STATS_W-1:0] miss_cnt
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    state_t r_state;
    state_t w_next;

    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_hit;

    logic              w_line_valid;
    logic [TAG_W-1:0]  w_line_tag;
    logic [DATA_W-1:0] w_line_data;
    logic              w_hit;
    logic              w_ack;
    logic              w_line_we;
    logic              w_is_rd;

    assign w_is_rd = (r_write == CACHE_RD);
    assign w_hit   = w_line_valid && (w_line_tag == r_addr[ADDR_W-1:IDX_W]);
    assign w_ack   = (r_state == RAM_ACC) && ram_ack;
    // Read misses allocate; writes only refresh a line that already hit.
    assign w_line_we = w_ack && (w_is_rd || r_hit);

    cache_line_store #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_store (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (r_addr[IDX_W-1:0]),
        .o_rd_valid (w_line_valid),
        .o_rd_tag   (w_line_tag),
        .o_rd_data  (w_line_data),
        .i_we       (w_line_we),
        .i_wr_idx   (r_addr[IDX_W-1:0]),
        .i_wr_tag   (r_addr[ADDR_W-1:IDX_W]),
        .i_wr_data  (w_is_rd ? ram_rdata : r_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (req_valid) w_next = LOOKUP;
            LOOKUP:  w_next = (w_is_rd && w_hit) ? RESP : RAM_ACC;
            RAM_ACC: if (ram_ack) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_hit   <= 1'b0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (r_state == LOOKUP) begin
                r_hit <= w_hit;
                if (w_is_rd && w_hit) r_rdata <= w_line_data;
            end
            if (w_ack && w_is_rd) r_rdata <= ram_rdata;
        end
    end

    // Handshake outputs are masked in the reset cycle itself.
    assign req_ready  = !rst && (r_state == IDLE);
    assign resp_valid = !rst && (r_state == RESP);
    assign resp_rdata = r_rdata;
    assign resp_hit   = r_hit;
    assign ram_req    = (r_state == RAM_ACC);
    assign ram_write  = r_write;
    assign ram_addr   = r_addr;
    assign ram_wdata  = r_wdata;

`ifdef CACHE_STATS_EN
    logic [STATS_W-1:0] r_hit_cnt;
    logic [STATS_W-1:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == RESP) begin
            if (r_hit) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
            end else begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
